io_bus_arbiter: RTL and testbench



---
 rtl/io_bus_arbiter_pkg.sv | 26 ++
 rtl/io_bus_arbiter_rr_pick.sv | 16 +
 rtl/io_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_io_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared encodings and the access legality rule for the IO-window bus arbiter.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package io_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IOARB_IDLE   = 2'd0,
        IOARB_ACCESS = 2'd1,
        IOARB_DONE   = 2'd2
    } ioarb_state_t;

    localparam logic IOARB_M0 = 1'b0;
    localparam logic IOARB_M1 = 1'b1;

    localparam int unsigned IOMEM_SIZE   = 64;
    localparam int unsigned IOMEMRO_SIZE = 16;

    // Last touched byte is formed in 33 bits so addresses near 2^32 cannot wrap into range.
    function automatic logic ioarb_illegal(input logic [31:0] addr, input logic [3:0] wen,
                                           input int unsigned mem_size, input int unsigned memro_size);
        logic [32:0] last_byte;
        last_byte = {1'b0, addr} + 33'd3;
        return (last_byte >= {1'b0, mem_size}) || ((wen != 4'd0) && (addr < memro_size));
    endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_pick.sv
// Two-way round-robin picker: the master that did not own the bus last wins a tie.
// Latency: combinational.
// Backpressure: masked requesters are simply not eligible.
module io_arb_rr_pick (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last_owner,
    output logic       valid,
    output logic       winner
);
    logic [1:0] elig;

    assign elig   = req & ~mask;
    assign valid  = |elig;
    assign winner = (elig == 2'b11) ? !last_owner : elig[1];
endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the IO slave between two masters; IOARB_LOCK_EN adds bus locking.
// Latency: request sampled at E, slave access in E+1, ack in E+2 (errors ack in E+1).
// Backpressure: masters hold req until ack; the acked owner is masked during its ack cycle.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int unsigned MEMRO_SIZE = IOMEMRO_SIZE,
    parameter int unsigned MEM_SIZE   = IOMEM_SIZE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wen,
    input  logic [31:0] m0_wdata,
    input  logic        m0_lock,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wen,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m0_ack,
    output logic        m0_err,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m_rdata,
    output logic [31:0] out_addr,
    output logic [3:0]  out_wen,
    output logic [31:0] out_wdata,
    input  logic [31:0] in_rdata
);
    ioarb_state_t state;
    logic         last_owner;
    logic [1:0]   req;
    logic [1:0]   lock_in;
    logic [1:0]   mask;
    logic         pick_vld;
    logic         pick_win;
    logic [31:0]  sel_addr;
    logic [31:0]  sel_wdata;
    logic [3:0]   sel_wen;
    logic         sel_err;

    assign req     = {m1_req, m0_req};
    assign lock_in = {m1_lock, m0_lock};

`ifdef IOARB_LOCK_EN
    logic locked;
`else
    logic unused_lock;
    assign unused_lock = ^lock_in;
`endif

    // last_owner doubles as the owner of the transaction in flight.
    always_comb begin
        mask = 2'b00;
        if (state == IOARB_DONE)
            mask[last_owner] = 1'b1;
`ifdef IOARB_LOCK_EN
        if (locked && lock_in[last_owner])
            mask[!last_owner] = 1'b1;
`endif
    end

    io_arb_rr_pick u_pick (
        .req        (req),
        .mask       (mask),
        .last_owner (last_owner),
        .valid      (pick_vld),
        .winner     (pick_win)
    );

    always_comb begin
        sel_addr  = pick_win ? m1_addr  : m0_addr;
        sel_wen   = pick_win ? m1_wen   : m0_wen;
        sel_wdata = pick_win ? m1_wdata : m0_wdata;
        sel_err   = ioarb_illegal(sel_addr, sel_wen, MEM_SIZE, MEMRO_SIZE);
    end

    // Bus outputs double as the transaction latch; they are only non-zero during ACCESS.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IOARB_IDLE;
            last_owner <= IOARB_M1;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m_rdata    <= 32'd0;
            out_addr   <= 32'd0;
            out_wen    <= 4'd0;
            out_wdata  <= 32'd0;
`ifdef IOARB_LOCK_EN
            locked     <= 1'b0;
`endif
        end else begin
            m0_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m1_ack    <= 1'b0;
            m1_err    <= 1'b0;
            out_addr  <= 32'd0;
            out_wen   <= 4'd0;
            out_wdata <= 32'd0;
            case (state)
                IOARB_ACCESS: begin
                    m_rdata <= in_rdata;
                    if (last_owner == IOARB_M1)
                        m1_ack <= 1'b1;
                    else
                        m0_ack <= 1'b1;
`ifdef IOARB_LOCK_EN
                    locked <= lock_in[last_owner];
`endif
                    state <= IOARB_DONE;
                end
                default: begin
`ifdef IOARB_LOCK_EN
                    if (!lock_in[last_owner])
                        locked <= 1'b0;
`endif
                    if (pick_vld) begin
                        last_owner <= pick_win;
                        if (sel_err) begin
                            if (pick_win == IOARB_M0) begin
                                m0_ack <= 1'b1;
                                m0_err <= 1'b1;
                            end else begin
                                m1_ack <= 1'b1;
                                m1_err <= 1'b1;
                            end
`ifdef IOARB_LOCK_EN
                            locked <= lock_in[pick_win];
`endif
                            state <= IOARB_DONE;
                        end else begin
                            out_addr  <= sel_addr;
                            out_wen   <= sel_wen;
                            out_wdata <= sel_wdata;
                            state     <= IOARB_ACCESS;
                        end
                    end else begin
                        state <= IOARB_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_io_bus_arbiter.sv
`timescale 1ns/1ps
module tb_io_bus_arbiter;
    localparam int unsigned MEM_SZ = 64;
    localparam int unsigned RO_SZ  = 16;
    localparam logic [31:0] LED_ADDR    = 32'h20;
    localparam logic [31:0] SEG_ADDR    = 32'h24;
    localparam logic [31:0] SWITCH_ADDR = 32'h28;
    localparam logic [3:0]  SW_IDX      = 4'd10;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic        lock;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0, m0_lock = 1'b0, m1_lock = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wen = '0, m1_wen = '0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m_rdata, out_addr, out_wdata, in_rdata;
    logic [3:0]  out_wen;
    logic [15:0] swi = 16'h0;
    logic [31:0] mem [16];

    io_bus_arbiter #(.MEMRO_SIZE(RO_SZ), .MEM_SIZE(MEM_SZ)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m0_ack(m0_ack), .m0_err(m0_err), .m1_ack(m1_ack), .m1_err(m1_err),
        .m_rdata(m_rdata), .out_addr(out_addr), .out_wen(out_wen), .out_wdata(out_wdata),
        .in_rdata(in_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h01010101 + 32'h80402010;
    endfunction

    // Slave: word RAM with a read-only switch register, combinational read.
    assign in_rdata = (out_addr[5:2] == SW_IDX) ? {16'h0, swi} : mem[out_addr[5:2]];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (out_wen[b]) mem[out_addr[5:2]][8*b +: 8] <= out_wdata[8*b +: 8];
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model: who is busy, who was served last, what each output should be.
    logic [1:0]  e_ack, e_err;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [3:0]  e_wen;
    logic        acc_on, done_on, last, lk;
    logic [31:0] ref_mem [16];

    txn_t q0[$];
    txn_t q1[$];
    logic [1:0] ackd = 2'b00;
    logic ack_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e_ack = 2'b00; e_err = 2'b00; e_rdata = '0; e_addr = '0; e_wdata = '0; e_wen = '0;
        acc_on = 1'b0; done_on = 1'b0; last = 1'b1; lk = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    endtask

    function automatic logic [31:0] slave_val(input logic [31:0] a);
        return (a[5:2] == SW_IDX) ? {16'h0, swi} : ref_mem[a[5:2]];
    endfunction

    task automatic tick();
        logic [1:0]  n_ack, n_err, elig, reqv, lockv;
        logic [31:0] n_rdata, n_addr, n_wdata, a, wd;
        logic [3:0]  n_wen, w;
        logic        n_acc, n_done, n_last, n_lk, win;
        reqv = {m1_req, m0_req};
        lockv = {m1_lock, m0_lock};
        n_ack = 2'b00; n_err = 2'b00; n_rdata = e_rdata; n_addr = '0; n_wdata = '0; n_wen = '0;
        n_acc = 1'b0; n_done = 1'b0; n_last = last; n_lk = lk;
        if (acc_on) begin
            n_rdata = slave_val(e_addr);
            for (int b = 0; b < 4; b++)
                if (e_wen[b]) ref_mem[e_addr[5:2]][8*b +: 8] = e_wdata[8*b +: 8];
            n_ack[last] = 1'b1;
            n_done = 1'b1;
`ifdef IOARB_LOCK_EN
            n_lk = lockv[last];
`endif
        end else begin
            elig = reqv;
            if (done_on) elig[last] = 1'b0;
`ifdef IOARB_LOCK_EN
            if (lk && lockv[last]) elig[!last] = 1'b0;
            if (!lockv[last]) n_lk = 1'b0;
`endif
            if (elig != 2'b00) begin
                win = (elig == 2'b11) ? !last : elig[1];
                n_last = win;
                a  = win ? m1_addr  : m0_addr;
                w  = win ? m1_wen   : m0_wen;
                wd = win ? m1_wdata : m0_wdata;
                if (({1'b0, a} + 33'd3 >= 33'(MEM_SZ)) || (w != 4'd0 && a < RO_SZ)) begin
                    n_ack[win] = 1'b1;
                    n_err[win] = 1'b1;
                    n_done = 1'b1;
`ifdef IOARB_LOCK_EN
                    n_lk = lockv[win];
`endif
                end else begin
                    n_acc = 1'b1; n_addr = a; n_wen = w; n_wdata = wd;
                end
            end
        end
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            e_ack = n_ack; e_err = n_err; e_rdata = n_rdata; e_addr = n_addr; e_wen = n_wen;
            e_wdata = n_wdata; acc_on = n_acc; done_on = n_done; last = n_last; lk = n_lk;
        end
        #1;
        chk("m0_ack", 32'(m0_ack), 32'(e_ack[0]));
        chk("m1_ack", 32'(m1_ack), 32'(e_ack[1]));
        chk("m0_err", 32'(m0_err), 32'(e_err[0]));
        chk("m1_err", 32'(m1_err), 32'(e_err[1]));
        chk("m_rdata", m_rdata, e_rdata);
        chk("out_addr", out_addr, e_addr);
        chk("out_wen", 32'(out_wen), 32'(e_wen));
        chk("out_wdata", out_wdata, e_wdata);
        if (m0_ack) ack_log.push_back(1'b0);
        if (m1_ack) ack_log.push_back(1'b1);
    endtask

    // Masters hold each transaction through its ack cycle and move on the cycle after.
    task automatic drive();
        if (ackd[0]) begin q0.delete(0); ackd[0] = 1'b0; end
        if (ackd[1]) begin q1.delete(0); ackd[1] = 1'b0; end
        if (e_ack[0]) ackd[0] = 1'b1;
        if (e_ack[1]) ackd[1] = 1'b1;
        if (q0.size() > 0) begin
            m0_req = 1'b1; m0_addr = q0[0].addr; m0_wen = q0[0].wen; m0_wdata = q0[0].wdata; m0_lock = q0[0].lock;
        end else begin
            m0_req = 1'b0; m0_addr = '0; m0_wen = '0; m0_wdata = '0; m0_lock = 1'b0;
        end
        if (q1.size() > 0) begin
            m1_req = 1'b1; m1_addr = q1[0].addr; m1_wen = q1[0].wen; m1_wdata = q1[0].wdata; m1_lock = q1[0].lock;
        end else begin
            m1_req = 1'b0; m1_addr = '0; m1_wen = '0; m1_wdata = '0; m1_lock = 1'b0;
        end
    endtask

    task automatic step();
        tick();
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        q0.delete(); q1.delete(); ackd = 2'b00;
        drive();
        tick(); tick();
        rst = 1'b1;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        case ($urandom_range(0, 5))
            0: t.addr = 32'hFFFFFFFE;
            1: t.addr = 32'($urandom_range(0, 72));
            default: t.addr = 32'($urandom_range(0, 15)) << 2;
        endcase
        t.wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
        t.wdata = $urandom;
        t.lock  = ($urandom_range(0, 7) == 0);
        return t;
    endfunction

    logic [2:0] obs_order;
    logic [2:0] exp_order;

    initial begin
        model_reset();
        do_reset();
        chk("rst_out_wen", 32'(out_wen), 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_acks", 32'({m1_ack, m0_ack, m1_err, m0_err}), 32'd0);

        // m0 LED write: one cycle of out_wen at E+1, ack at E+2.
        q0.push_back('{LED_ADDR, 4'b0011, 32'h0000A5A5, 1'b0});
        drive();
        step();
        chk("led_wen_e1", 32'(out_wen), 32'h3);
        step();
        chk("led_ack_e2", 32'({m0_ack, m0_err}), 32'b10);
        chk("led_wen_e2", 32'(out_wen), 32'd0);
        step();
        q0.push_back('{LED_ADDR, 4'b0000, 32'h0, 1'b0});
        drive();
        step(); step();
        chk("led_readback", 32'(m_rdata[15:0]), 32'hA5A5);
        step();

        // m1 switch read.
        swi = 16'h1234;
        q1.push_back('{SWITCH_ADDR, 4'b0000, 32'h0, 1'b0});
        drive();
        step(); step();
        chk("swi_ack", 32'(m1_ack), 32'd1);
        chk("swi_rdata", 32'(m_rdata[15:0]), 32'h1234);
        step();

        // Write to the read-only region: immediate error, no slave activity.
        q0.push_back('{32'h0, 4'b1111, 32'hFFFF_FFFF, 1'b0});
        drive();
        step();
        chk("ro_ack_err", 32'({m0_ack, m0_err}), 32'b11);
        chk("ro_no_wen", 32'(out_wen), 32'd0);
        step(); step();

        // Out-of-range read: error, read data untouched.
        q1.push_back('{MEM_SZ - 2, 4'b0000, 32'h0, 1'b0});
        drive();
        step();
        chk("range_ack_err", 32'({m1_ack, m1_err}), 32'b11);
        chk("range_rdata_hold", m_rdata, 32'h00001234);
        step(); step();

        // Simultaneous requests from reset: m0, then m1, then m0 again.
        do_reset();
        q0.push_back('{SEG_ADDR, 4'b1111, 32'hCAFE0001, 1'b0});
        q1.push_back('{LED_ADDR, 4'b0000, 32'h0, 1'b0});
        q0.push_back('{32'h30, 4'b0000, 32'h0, 1'b0});
        drive();
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 2) chk("rr_first_m0", 32'(m0_ack), 32'd1);
            if (k == 4) chk("rr_then_m1", 32'(m1_ack), 32'd1);
            if (k == 6) chk("rr_third_m0", 32'(m0_ack), 32'd1);
            drive();
        end
        step(); step();

        // Reset during ACCESS drops the transaction.
        q0.push_back('{SEG_ADDR, 4'b1111, 32'h12345678, 1'b0});
        drive();
        step();
        chk("mid_wen", 32'(out_wen), 32'hF);
        rst = 1'b0;
        tick();
        chk("mid_rst_wen", 32'(out_wen), 32'd0);
        chk("mid_rst_noack", 32'(m0_ack), 32'd0);
        q0.delete(); ackd = 2'b00;
        drive();
        tick();
        rst = 1'b1;

        // Lock scenario: m0 issues two locked writes while m1 keeps requesting.
        ack_log.delete();
        q0.push_back('{LED_ADDR, 4'b1111, 32'h11111111, 1'b1});
        q0.push_back('{SEG_ADDR, 4'b1111, 32'h22222222, 1'b1});
        q1.push_back('{LED_ADDR, 4'b0000, 32'h0, 1'b0});
        drive();
        for (int k = 0; k < 12; k++) step();
`ifdef IOARB_LOCK_EN
        exp_order = 3'b001;
`else
        exp_order = 3'b010;
`endif
        chk("lock_ack_count", 32'(ack_log.size()), 32'd3);
        obs_order = (ack_log.size() >= 3) ? {ack_log[0], ack_log[1], ack_log[2]} : 3'bxxx;
        chk("lock_order", 32'(obs_order), 32'(exp_order));

        // Random traffic from both masters against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (q0.size() < 2 && $urandom_range(0, 2) != 0) q0.push_back(rand_txn());
            if (q1.size() < 2 && $urandom_range(0, 2) != 0) q1.push_back(rand_txn());
            if ($urandom_range(0, 31) == 0) swi = 16'($urandom);
            drive();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
